// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parameterised single-clock FIFO, any DEPTH >= 2, with standard
// registered read or first-word-fall-through read selected by FWFT.
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
  always_comb begin
    rd_acc     = rd_en_i && !empty_o && !flush_i;
    wr_acc     = wr_en_i && (!full_o || rd_acc) && !flush_i;
    wr_ptr_d   = flush_i ? '0 : !wr_acc ? wr_ptr_q : wr_ptr_q == PTR_MAX ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d   = flush_i ? '0 : !rd_acc ? rd_ptr_q : rd_ptr_q == PTR_MAX ? '0 : rd_ptr_q + 1'b1;
    cnt_d      = flush_i ? '0 : cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d      = wr_en_i && !wr_acc && !flush_i;
    unf_d      = rd_en_i && !rd_acc && !flush_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_acc && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
  end
  // In FWFT mode the last popped word stays visible once the FIFO runs dry.
  assign rd_data_o      = (FWFT != 0 && !empty_o) ? mem_q[rd_ptr_q] : rd_data_q;
  assign rd_valid_o     = (FWFT != 0) ? !empty_o : rd_valid_q;
  assign count_o        = cnt_q;
  assign full_o         = cnt_q == CNT_W'(DEPTH);
  assign empty_o        = cnt_q == '0;
  assign almost_full_o  = cnt_q >= CNT_W'(AF_LEVEL);
  assign almost_empty_o = cnt_q <= CNT_W'(AE_LEVEL);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed checks of three FIFO configurations sharing one stimulus stream.
module tb_param_sync_fifo;
  logic clk = 1'b0, rst = 1'b1, fl = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wd = '0;
  logic [7:0] a_rd, b_rd, c_rd;
  logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [4:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;
  int checks = 0, errors = 0;
  logic [7:0] q [$];
  logic [7:0] exp_d, d;
  logic racc, wacc, w, r;
  always #5 clk = ~clk;
  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(fl), .wr_en_i(wr), .wr_data_i(wd), .rd_en_i(rd),
    .rd_data_o(a_rd), .rd_valid_o(a_rv), .full_o(a_full), .empty_o(a_empty),
    .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf), .underflow_o(a_unf),
    .count_o(a_cnt));
  param_sync_fifo #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(fl), .wr_en_i(wr), .wr_data_i(wd), .rd_en_i(rd),
    .rd_data_o(b_rd), .rd_valid_o(b_rv), .full_o(b_full), .empty_o(b_empty),
    .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ovf), .underflow_o(b_unf),
    .count_o(b_cnt));
  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(fl), .wr_en_i(wr), .wr_data_i(wd), .rd_en_i(rd),
    .rd_data_o(c_rd), .rd_valid_o(c_rv), .full_o(c_full), .empty_o(c_empty),
    .almost_full_o(c_af), .almost_empty_o(c_ae), .overflow_o(c_ovf), .underflow_o(c_unf),
    .count_o(c_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w_i, input logic [7:0] d_i, input logic r_i, input logic f_i);
    wr = w_i; wd = d_i; rd = r_i; fl = f_i;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0;
  endtask
  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_cnt", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_fw_rd", c_rd, 0);
    chk("rst_fw_rv", c_rv, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("fill_cnt", a_cnt, i + 1);
      chk("fill_af", a_af, (i + 1) >= 14);
      chk("fill_ae", a_ae, (i + 1) <= 2);
    end
    chk("fill_full", a_full, 1);
    cyc(1, 8'hEE, 0, 0);
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_cnt", a_cnt, 16);
    cyc(0, 0, 0, 0);
    chk("ovf_clear", a_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'hA0 + 8'(i), 1, 0);
      chk("full_rw_data", a_rd, i);
      chk("full_rw_rv", a_rv, 1);
      chk("full_rw_cnt", a_cnt, 16);
      chk("full_rw_ovf", a_ovf, 0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_data", a_rd, i < 8 ? 8 + i : 8'hA0 + i - 8);
      chk("drain_rv", a_rv, 1);
    end
    chk("drain_empty", a_empty, 1);
    cyc(0, 0, 0, 0);
    chk("idle_rv", a_rv, 0);
    chk("idle_hold", a_rd, 8'hA7);
    cyc(0, 0, 1, 0);
    chk("unf_pulse", a_unf, 1);
    chk("unf_cnt", a_cnt, 0);
    chk("unf_rv", a_rv, 0);
    cyc(1, 8'h5A, 1, 0);
    chk("erw_unf", a_unf, 1);
    chk("erw_cnt", a_cnt, 1);
    cyc(0, 0, 1, 0);
    chk("erw_data", a_rd, 8'h5A);
    chk("erw_rv", a_rv, 1);
    chk("erw_unf_clr", a_unf, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0, 0);
    chk("pre_flush_cnt", a_cnt, 10);
    cyc(1, 8'h77, 0, 1);
    chk("flush_cnt", a_cnt, 0);
    chk("flush_empty", a_empty, 1);
    chk("flush_ovf", a_ovf, 0);
    chk("flush_hold", a_rd, 8'h5A);
    cyc(0, 0, 1, 1);
    chk("flush_no_unf", a_unf, 0);
    cyc(0, 0, 1, 0);
    chk("flush_no_write", a_unf, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        cyc(1, 8'(16 * k + j), 0, 0);
        chk("d5_cnt", b_cnt, j + 1);
        chk("d5_af", b_af, (j + 1) >= 3);
      end
      chk("d5_full", b_full, 1);
      for (int j = 0; j < 5; j++) begin
        cyc(0, 0, 1, 0);
        chk("d5_data", b_rd, 16 * k + j);
      end
      chk("d5_empty", b_empty, 1);
    end
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 8'h33, 0, 0);
    chk("fw_rv", c_rv, 1);
    chk("fw_data", c_rd, 8'h33);
    cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h55, 0, 0);
    chk("fw_head_held", c_rd, 8'h33);
    cyc(0, 0, 1, 0);
    chk("fw_pop1", c_rd, 8'h44);
    cyc(0, 0, 1, 0);
    chk("fw_pop2", c_rd, 8'h55);
    cyc(0, 0, 1, 0);
    chk("fw_empty", c_empty, 1);
    chk("fw_rv_low", c_rv, 0);
    chk("fw_last_held", c_rd, 8'h55);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    rst = 1'b1;
    cyc(1, 8'h99, 1, 0);
    rst = 1'b0;
    chk("midrst_cnt", a_cnt, 0);
    chk("midrst_ovf", a_ovf, 0);
    chk("midrst_unf", a_unf, 0);
    chk("midrst_empty", a_empty, 1);
    q.delete();
    for (int i = 0; i < 2000; i++) begin
      w = $urandom_range(0, 3) < ((i % 400) < 200 ? 3 : 1);
      r = $urandom_range(0, 3) < ((i % 400) < 200 ? 1 : 3);
      d = 8'($urandom);
      racc = r && q.size() > 0;
      wacc = w && (q.size() < 16 || racc);
      if (racc) exp_d = q.pop_front();
      if (wacc) q.push_back(d);
      cyc(w, d, r, 0);
      chk("rnd_cnt", a_cnt, q.size());
      chk("rnd_rv", a_rv, racc);
      if (racc) chk("rnd_data", a_rd, exp_d);
      chk("rnd_ovf", a_ovf, w && !wacc);
      chk("rnd_unf", a_unf, r && !racc);
      chk("rnd_fw_cnt", c_cnt, q.size());
      if (q.size() > 0) chk("rnd_fw_head", c_rd, q[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage words; any integer >=2, not restricted to powers of two.
REQ-003 Parameter FWFT, default 0; 0 = standard registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AF_LEVEL, default DEPTH-2; almost-full threshold, legal range 1..DEPTH-1.
REQ-005 Parameter AE_LEVEL, default 2; almost-empty threshold, legal range 1..DEPTH-1.
REQ-006 Derived CNT_W = $clog2(DEPTH+1); not user-overridable.
REQ-007 clk_i  input  1  single clock; all logic on rising edge.
REQ-008 rst_i  input  1  reset; synchronous, active-high.
REQ-009 flush_i  input  1  synchronous clear of FIFO contents.
REQ-010 wr_en_i  input  1  write request.
REQ-011 wr_data_i  input  DATA_W  write data.
REQ-012 rd_en_i  input  1  read request.
REQ-013 rd_data_o  output  DATA_W  read data.
REQ-014 rd_valid_o  output  1  rd_data_o holds a freshly popped word (standard mode) / head word present (FWFT).
REQ-015 full_o, empty_o  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-016 almost_full_o, almost_empty_o  output  1 each  occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-017 overflow_o, underflow_o  output  1 each  rejected write / rejected read, one-cycle pulse.
REQ-018 count_o  output  CNT_W  current occupancy.

Function
REQ-019 Write accepted iff wr_en_i && (!full_o || read accepted same cycle); accepted word stored at write pointer.
REQ-020 Read accepted iff rd_en_i && !empty_o.
REQ-021 Pointers range 0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly (no power-of-two masking).
REQ-022 count_o: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write; all flags derived from registered count, valid in the cycle after the edge.
REQ-023 Full with wr_en_i and rd_en_i: both accepted, popped word is oldest entry, count stays DEPTH, no overflow.
REQ-024 Empty with wr_en_i and rd_en_i: write accepted, read rejected, underflow_o pulses, count becomes 1.
REQ-025 overflow_o high exactly one cycle after each rejected write; underflow_o likewise after each rejected read; no pulse when flush_i high.
REQ-026 FWFT=0: rd_data_o registered, updated the cycle after an accepted read, rd_valid_o high that cycle only; rd_data_o holds its value otherwise.
REQ-027 FWFT=1: rd_data_o presents head word combinationally from storage whenever !empty_o, rd_valid_o = !empty_o; accepted read advances to next word in the following cycle; zero-latency write-to-visible after the write edge.
REQ-028 flush_i high: pointers and count to 0, rd_valid_o 0, wr/rd requests that cycle ignored; storage array contents not cleared; rd_data_o held.
REQ-029 Priority per edge: rst_i > flush_i > read/write.

Reset
REQ-030 rst_i high at a rising edge: pointers 0, count_o 0, empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0, overflow_o 0, underflow_o 0, rd_valid_o 0, rd_data_o 0.
REQ-031 Reset asserted mid-operation discards all contents; requests in reset cycles ignored, no overflow/underflow pulse.
REQ-032 Storage array not reset.

Verification
REQ-033 DEPTH=16, FWFT=0: write 0..15 -> full_o=1, count_o=16, almost_full_o from count 14; 17th write 0xEE -> overflow_o pulse 1 cycle, contents unchanged.
REQ-034 Full, 8 cycles simultaneous R/W writing 0xA0..0xA7 -> reads return 0..7, count_o stays 16; drain -> 8..15 then 0xA0..0xA7, empty_o=1.
REQ-035 Empty, rd_en_i -> underflow_o pulse, count_o 0; empty with simultaneous R/W data 0x5A -> count_o=1, underflow_o pulse, next read returns 0x5A.
REQ-036 DEPTH=5 (non-power-of-two): 3 full wrap cycles of write/read -> data order preserved, pointers wrap 4->0.
REQ-037 FWFT=1: write 0x33 into empty -> next cycle rd_valid_o=1, rd_data_o=0x33 without rd_en_i; pop -> empty_o=1.
REQ-038 Fill 10 words, pulse flush_i with wr_en_i high -> count_o=0, empty_o=1, no write taken; 2000-cycle random R/W against scoreboard -> zero mismatches.
